// File: rtl/reg_to_axi_lite_bridge.sv
// Regbus responder to AXI-Lite initiator bridge: one outstanding transfer,
// registered FSM outputs, 48-bit address / 32-bit data default bus types.

package reg_to_axi_lite_bridge_pkg;

   typedef struct packed {
      logic [47:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_a48_d32_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_a48_d32_rsp_t;

   typedef struct packed {
      logic [47:0] addr;
      logic [2:0]  prot;
   } axi_lite_a48_ax_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } axi_lite_d32_w_t;

   typedef struct packed {
      logic [1:0] resp;
   } axi_lite_b_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } axi_lite_d32_r_t;

   typedef struct packed {
      axi_lite_a48_ax_t aw;
      logic             aw_valid;
      axi_lite_d32_w_t  w;
      logic             w_valid;
      logic             b_ready;
      axi_lite_a48_ax_t ar;
      logic             ar_valid;
      logic             r_ready;
   } axi_lite_a48_d32_req_t;

   typedef struct packed {
      logic            aw_ready;
      logic            w_ready;
      axi_lite_b_t     b;
      logic            b_valid;
      logic            ar_ready;
      axi_lite_d32_r_t r;
      logic            r_valid;
   } axi_lite_a48_d32_rsp_t;

endpackage

module reg_to_axi_lite_bridge #(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned DataWidth = 32,
   parameter type reg_req_t      = reg_to_axi_lite_bridge_pkg::reg_a48_d32_req_t,
   parameter type reg_rsp_t      = reg_to_axi_lite_bridge_pkg::reg_a48_d32_rsp_t,
   parameter type axi_lite_req_t = reg_to_axi_lite_bridge_pkg::axi_lite_a48_d32_req_t,
   parameter type axi_lite_rsp_t = reg_to_axi_lite_bridge_pkg::axi_lite_a48_d32_rsp_t
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  reg_req_t      reg_req_i,
   output reg_rsp_t      reg_rsp_o,
   output axi_lite_req_t axi_lite_req_o,
   input  axi_lite_rsp_t axi_lite_rsp_i
);

   localparam int unsigned StrbWidth = DataWidth / 8;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WRITE  = 3'd1;
   localparam logic [2:0] WAIT_B = 3'd2;
   localparam logic [2:0] READ   = 3'd3;
   localparam logic [2:0] WAIT_R = 3'd4;
   localparam logic [2:0] RESP   = 3'd5;

   logic [2:0]           state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic [StrbWidth-1:0] wstrb_q, wstrb_d;
   logic                 write_q, write_d;
   logic                 aw_done_q, aw_done_d;
   logic                 w_done_q, w_done_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                 error_q, error_d;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      write_d   = write_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      error_d   = error_q;

      case (state_q)
         IDLE: begin
            if (reg_req_i.valid) begin
               addr_d    = reg_req_i.addr;
               wdata_d   = reg_req_i.wdata;
               wstrb_d   = reg_req_i.wstrb;
               write_d   = reg_req_i.write;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rdata_d   = '0;
               error_d   = 1'b0;
               state_d   = reg_req_i.write ? WRITE : READ;
            end
         end
         WRITE: begin
            // A done flag also gates its valid, so ready while done is ignored.
            if (!aw_done_q && axi_lite_rsp_i.aw_ready) aw_done_d = 1'b1;
            if (!w_done_q && axi_lite_rsp_i.w_ready) w_done_d = 1'b1;
            if (aw_done_d && w_done_d) state_d = WAIT_B;
         end
         WAIT_B: begin
            if (axi_lite_rsp_i.b_valid) begin
               error_d = (axi_lite_rsp_i.b.resp != 2'b00);
               state_d = RESP;
            end
         end
         READ: begin
            if (axi_lite_rsp_i.ar_ready) state_d = WAIT_R;
         end
         WAIT_R: begin
            if (axi_lite_rsp_i.r_valid) begin
               rdata_d = axi_lite_rsp_i.r.data;
               error_d = (axi_lite_rsp_i.r.resp != 2'b00);
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      axi_lite_req_o          = '0;
      axi_lite_req_o.aw.addr  = addr_q;
      axi_lite_req_o.aw.prot  = 3'b000;
      axi_lite_req_o.aw_valid = (state_q == WRITE) && !aw_done_q;
      axi_lite_req_o.w.data   = wdata_q;
      axi_lite_req_o.w.strb   = wstrb_q;
      axi_lite_req_o.w_valid  = (state_q == WRITE) && !w_done_q;
      axi_lite_req_o.b_ready  = (state_q == WAIT_B);
      axi_lite_req_o.ar.addr  = addr_q;
      axi_lite_req_o.ar.prot  = 3'b000;
      axi_lite_req_o.ar_valid = (state_q == READ);
      axi_lite_req_o.r_ready  = (state_q == WAIT_R);

      reg_rsp_o       = '0;
      reg_rsp_o.ready = (state_q == RESP);
      reg_rsp_o.rdata = (state_q == RESP) ? rdata_q : '0;
      reg_rsp_o.error = (state_q == RESP) ? error_q : 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         write_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         write_q   <= write_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         error_q   <= error_d;
      end
   end

endmodule

// File: tb/tb_reg_to_axi_lite_bridge.sv
// Bench for reg_to_axi_lite_bridge: memory-backed AXI-Lite responder, reference
// memory model, and a response scoreboard drained by an independent monitor.

module tb_reg_to_axi_lite_bridge;
   import reg_to_axi_lite_bridge_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   reg_a48_d32_req_t      reg_req;
   reg_a48_d32_rsp_t      reg_rsp;
   axi_lite_a48_d32_req_t axi_req;
   axi_lite_a48_d32_rsp_t axi_rsp;

   reg_to_axi_lite_bridge #(
      .AddrWidth     (48),
      .DataWidth     (32),
      .reg_req_t     (reg_a48_d32_req_t),
      .reg_rsp_t     (reg_a48_d32_rsp_t),
      .axi_lite_req_t(axi_lite_a48_d32_req_t),
      .axi_lite_rsp_t(axi_lite_a48_d32_rsp_t)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .reg_req_i     (reg_req),
      .reg_rsp_o     (reg_rsp),
      .axi_lite_req_o(axi_req),
      .axi_lite_rsp_i(axi_rsp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        error;
      int          start;
      bit          chk_lat;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [31:0] mdl_mem[logic [47:0]];
   logic [31:0] slv_mem[logic [47:0]];
   logic [47:0] pool[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_msg(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic finish_bench();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   endtask

   function automatic logic [31:0] init_word(input logic [47:0] a);
      return a[31:0] ^ 32'hA5C3_1E70;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mdl_rd(input logic [47:0] a);
      return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] slv_rd(input logic [47:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_aw_valid"}, 64'(axi_req.aw_valid), 64'd0);
      chk({tag, "_w_valid"},  64'(axi_req.w_valid),  64'd0);
      chk({tag, "_ar_valid"}, 64'(axi_req.ar_valid), 64'd0);
      chk({tag, "_b_ready"},  64'(axi_req.b_ready),  64'd0);
      chk({tag, "_r_ready"},  64'(axi_req.r_ready),  64'd0);
      chk({tag, "_ready"},    64'(reg_rsp.ready),    64'd0);
      chk({tag, "_rdata"},    64'(reg_rsp.rdata),    64'd0);
      chk({tag, "_error"},    64'(reg_rsp.error),    64'd0);
   endtask

   // Scoreboard side: every reg ready pulse consumes one expected response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && reg_rsp.ready) begin
            if (exp_q.size() == 0) begin
               fail_msg("unexpected_reg_ready");
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", 64'(reg_rsp.rdata), 64'(e.rdata));
               chk("rsp_error", 64'(reg_rsp.error), 64'(e.error));
               if (e.chk_lat) chk("rsp_latency", 64'(cyc - e.start), 64'd3);
            end
         end
      end
   end

   // Issues one regbus transfer and plays the AXI-Lite responder for it.
   task automatic do_txn(input logic wr, input logic [47:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] resp, input int aw_dly,
                         input int w_dly, input int ar_dly, input int rsp_dly);
      exp_t        e;
      logic [31:0] cur;
      int          c, last_hs;
      bit          aw_done, w_done, ar_done, rsp_done, addr_done, rsp_was, fin;
      bit          aw_prev, w_prev, ar_prev;
      logic [47:0] seen_addr;
      logic [31:0] seen_data;
      logic [3:0]  seen_strb;

      cur       = mdl_rd(a);
      e.error   = (resp != 2'b00);
      e.start   = cyc;
      e.chk_lat = (rsp_dly == 0) && (wr ? (aw_dly == 0 && w_dly == 0) : (ar_dly == 0));
      if (wr) begin
         e.rdata = '0;
         if (resp == 2'b00) mdl_mem[a] = merge(cur, d, s);
      end else begin
         e.rdata = cur;
      end
      exp_q.push_back(e);

      reg_req.valid = 1'b1;
      reg_req.write = wr;
      reg_req.addr  = a;
      reg_req.wdata = d;
      reg_req.wstrb = s;

      c = 0; last_hs = 0;
      aw_done = 0; w_done = 0; ar_done = 0; rsp_done = 0; fin = 0;
      aw_prev = 0; w_prev = 0; ar_prev = 0;
      seen_addr = '0; seen_data = '0; seen_strb = '0;

      forever begin
         addr_done        = wr ? (aw_done && w_done) : ar_done;
         rsp_was          = rsp_done;
         axi_rsp.aw_ready = wr && !aw_done && (c >= 1 + aw_dly);
         axi_rsp.w_ready  = wr && !w_done && (c >= 1 + w_dly);
         axi_rsp.ar_ready = !wr && !ar_done && (c >= 1 + ar_dly);
         axi_rsp.b_valid  = wr && addr_done && !rsp_done && (c >= last_hs + 1 + rsp_dly);
         axi_rsp.b.resp   = resp;
         axi_rsp.r_valid  = !wr && addr_done && !rsp_done && (c >= last_hs + 1 + rsp_dly);
         axi_rsp.r.resp   = resp;
         axi_rsp.r.data   = addr_done ? slv_rd(seen_addr) : 32'h0;

         @(negedge clk);
         if (wr) begin
            chk("ar_valid_on_write", 64'(axi_req.ar_valid), 64'd0);
            chk("r_ready_on_write",  64'(axi_req.r_ready),  64'd0);
            if (aw_done) chk("aw_reissue", 64'(axi_req.aw_valid), 64'd0);
            else begin
               if (aw_prev) chk("aw_valid_held", 64'(axi_req.aw_valid), 64'd1);
               if (axi_req.aw_valid) begin
                  if (!aw_prev) chk("aw_first_cycle", 64'(c), 64'd1);
                  chk("aw_addr", 64'(axi_req.aw.addr), 64'(a));
                  chk("aw_prot", 64'(axi_req.aw.prot), 64'd0);
                  if (axi_rsp.aw_ready) begin aw_done = 1; seen_addr = axi_req.aw.addr; end
               end
               aw_prev = axi_req.aw_valid;
            end
            if (w_done) chk("w_reissue", 64'(axi_req.w_valid), 64'd0);
            else begin
               if (w_prev) chk("w_valid_held", 64'(axi_req.w_valid), 64'd1);
               if (axi_req.w_valid) begin
                  if (!w_prev) chk("w_first_cycle", 64'(c), 64'd1);
                  chk("w_data", 64'(axi_req.w.data), 64'(d));
                  chk("w_strb", 64'(axi_req.w.strb), 64'(s));
                  if (axi_rsp.w_ready) begin
                     w_done = 1; seen_data = axi_req.w.data; seen_strb = axi_req.w.strb;
                  end
               end
               w_prev = axi_req.w_valid;
            end
            if (!addr_done || rsp_was) chk("b_ready_outside_wait", 64'(axi_req.b_ready), 64'd0);
            else if (axi_rsp.b_valid && axi_req.b_ready) begin
               rsp_done = 1;
               if (resp == 2'b00) slv_mem[seen_addr] = merge(slv_rd(seen_addr), seen_data, seen_strb);
            end
            if (!addr_done && aw_done && w_done) last_hs = c;
         end else begin
            chk("aw_valid_on_read", 64'(axi_req.aw_valid), 64'd0);
            chk("w_valid_on_read",  64'(axi_req.w_valid),  64'd0);
            chk("b_ready_on_read",  64'(axi_req.b_ready),  64'd0);
            if (ar_done) chk("ar_reissue", 64'(axi_req.ar_valid), 64'd0);
            else begin
               if (ar_prev) chk("ar_valid_held", 64'(axi_req.ar_valid), 64'd1);
               if (axi_req.ar_valid) begin
                  if (!ar_prev) chk("ar_first_cycle", 64'(c), 64'd1);
                  chk("ar_addr", 64'(axi_req.ar.addr), 64'(a));
                  chk("ar_prot", 64'(axi_req.ar.prot), 64'd0);
                  if (axi_rsp.ar_ready) begin ar_done = 1; seen_addr = axi_req.ar.addr; end
               end
               ar_prev = axi_req.ar_valid;
            end
            if (!addr_done || rsp_was) chk("r_ready_outside_wait", 64'(axi_req.r_ready), 64'd0);
            else if (axi_rsp.r_valid && axi_req.r_ready) rsp_done = 1;
            if (!addr_done && ar_done) last_hs = c;
         end
         if (reg_rsp.ready) begin
            fin = 1;
            chk("ready_after_resp_beat", 64'(rsp_was), 64'd1);
         end

         @(posedge clk);
         #1;
         c++;
         if (fin) break;
         if (c > 200) begin
            fail_msg("txn_timeout");
            finish_bench();
         end
      end
      reg_req.valid = 1'b0;
      axi_rsp       = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_expired");
      $fatal(1, "bench watchdog");
   end

   initial begin
      logic [47:0] a;
      logic [1:0]  rr;
      bit          got;

      reg_req = '0;
      axi_rsp = '0;
      rst     = 1'b1;
      for (int i = 0; i < 8; i++) pool[i] = {16'($urandom_range(0, 65535)), 32'($urandom)};
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed: minimum latency write/read, stalls, error responses, zero strobe.
      do_txn(1'b1, 48'h0000_0200_0010, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0, 0);
      do_txn(1'b0, 48'h0000_0200_0010, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0);
      do_txn(1'b1, 48'h0000_0100_0004, 32'h12345678, 4'hF, 2'b00, 0, 0, 0, 0);
      do_txn(1'b0, 48'h0000_0100_0004, 32'h0, 4'h0, 2'b00, 0, 0, 3, 1);
      do_txn(1'b1, 48'h0000_0300_0008, 32'h0BAD_F00D, 4'h5, 2'b00, 2, 0, 0, 0);
      do_txn(1'b1, 48'h0000_0300_000C, 32'h1111_2222, 4'hF, 2'b10, 0, 2, 0, 0);
      do_txn(1'b1, 48'h0000_0400_0000, 32'hCAFEF00D, 4'hF, 2'b00, 0, 0, 0, 0);
      do_txn(1'b0, 48'h0000_0400_0000, 32'h0, 4'h0, 2'b11, 0, 0, 0, 0);
      do_txn(1'b1, 48'h0000_0400_0000, 32'hFFFF_FFFF, 4'h0, 2'b00, 1, 1, 0, 2);
      do_txn(1'b0, 48'h0000_0400_0000, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0);
      do_txn(1'b1, 48'h0000_0300_0008, 32'h7777_8888, 4'hC, 2'b00, 0, 0, 0, 0);
      do_txn(1'b0, 48'h0000_0300_0008, 32'h0, 4'h0, 2'b00, 0, 0, 1, 0);

      for (int n = 0; n < 150; n++) begin
         a  = pool[$urandom_range(0, 7)];
         rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         do_txn(1'($urandom_range(0, 1)), a, 32'($urandom), 4'($urandom_range(0, 15)), rr,
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
      end

      // Abort a read in WAIT_R; it must never produce a reg response.
      reg_req.valid    = 1'b1;
      reg_req.write    = 1'b0;
      reg_req.addr     = pool[0];
      axi_rsp.ar_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (axi_req.ar_valid) got = 1;
         @(posedge clk);
         #1;
      end
      if (!got) fail_msg("abort_ar_timeout");
      reg_req.valid    = 1'b0;
      axi_rsp.ar_ready = 1'b0;
      @(negedge clk);
      chk("abort_in_wait_r", 64'(axi_req.r_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_abort");
      @(posedge clk);
      #1;
      axi_rsp.r_valid = 1'b1;
      axi_rsp.r.data  = 32'hBAD0_BAD0;
      axi_rsp.r.resp  = 2'b00;
      repeat (3) begin
         @(negedge clk);
         chk("stray_r_ready", 64'(axi_req.r_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      axi_rsp = '0;
      do_txn(1'b0, pool[1], 32'h0, 4'h0, 2'b00, 0, 0, 0, 0);

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      finish_bench();
   end

endmodule
